// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter slice.
// Width defaults match the ram instance; LOCK_NONE marks an idle lock.
package ram_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;

    localparam int LOCK_W = 4;
    localparam logic [LOCK_W-1:0] LOCK_NONE = 4'hF;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans upward from ptr+1 with wrap and returns the first active request.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int IW = $clog2(NUM_REQ);

    int j;

    // first requester after the pointer wins
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter in front of a single-port RAM.
// Supports locked bursts, bounded so a locker cannot starve others.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [ADDR_WIDTH-1:0]         ram_address,
    output logic [DATA_WIDTH-1:0]         ram_data_in,
    output logic                          ram_write_en,
    input  logic [DATA_WIDTH-1:0]         ram_data_out
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      rr_idx;
    logic [NUM_REQ-1:0] rr_gnt;
    logic               rr_any;

    logic [LOCK_W-1:0]  lock_owner;
    logic [BW-1:0]      burst_cnt;
    logic [IW-1:0]      lock_idx;

    logic [NUM_REQ-1:0] win_gnt;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      sel_idx;
    logic               any_gnt;
    logic               lock_hit;
    logic               is_read;

    assign lock_idx = lock_owner[IW-1:0];

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    // locked owner overrides round-robin until its burst budget is spent
    always_comb begin
        lock_hit = (lock_owner != LOCK_NONE)
                 && req[lock_idx]
                 && (burst_cnt < BURST_MAX);
        win_gnt  = rr_gnt;
        win_idx  = rr_idx;
        any_gnt  = rr_any;
        if (lock_hit) begin
            win_gnt           = '0;
            win_gnt[lock_idx] = 1'b1;
            win_idx           = lock_idx;
            any_gnt           = 1'b1;
        end
        sel_idx = any_gnt ? win_idx : rr_ptr;
        is_read = any_gnt && !req_we[win_idx];
    end

    assign gnt          = rst_n ? win_gnt : '0;
    assign ram_write_en = rst_n & any_gnt & req_we[sel_idx];
    assign ram_address  = req_addr[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign ram_data_in  = req_wdata[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];

    // pointer, lock owner and burst counter advance on every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= IW'(NUM_REQ - 1);
            lock_owner <= LOCK_NONE;
            burst_cnt  <= '0;
        end else if (any_gnt) begin
            rr_ptr <= win_idx;
            if (req_lock[win_idx]) begin
                lock_owner <= LOCK_W'(win_idx);
                if (lock_hit && (lock_idx == win_idx))
                    burst_cnt <= burst_cnt + 1'b1;
                else
                    burst_cnt <= BW'(1);
            end else begin
                lock_owner <= LOCK_NONE;
                burst_cnt  <= '0;
            end
        end else begin
            lock_owner <= LOCK_NONE;
            burst_cnt  <= '0;
        end
    end

    // capture read data and flag the reader for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            rd_valid <= is_read ? win_gnt : '0;
            if (is_read)
                rd_data <= ram_data_out;
        end
    end

endmodule
